// File: rtl/uart_text_buffer_if.sv
// Byte-input, read-port and status signals of the UART text buffer.
// master = the UART/pixel side, slave = the text buffer.
interface uart_text_buffer_if #(
    parameter int COLS = 16,
    parameter int ROWS = 4
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic          i_RX_DV;
    logic [7:0]    i_RX_Byte;
    logic [CW-1:0] i_Rd_Col;
    logic [RW-1:0] i_Rd_Row;
    logic [7:0]    o_Rd_Char;
    logic [CW-1:0] o_Cursor_Col;
    logic [RW-1:0] o_Cursor_Row;
    logic [7:0]    o_Last_Byte;
    logic          o_Busy;
    logic          o_Drop;

    modport master (
        output i_RX_DV, i_RX_Byte, i_Rd_Col, i_Rd_Row,
        input  o_Rd_Char, o_Cursor_Col, o_Cursor_Row, o_Last_Byte, o_Busy, o_Drop
    );

    modport slave (
        input  i_RX_DV, i_RX_Byte, i_Rd_Col, i_Rd_Row,
        output o_Rd_Char, o_Cursor_Col, o_Cursor_Row, o_Last_Byte, o_Busy, o_Drop
    );
endinterface

// File: rtl/uart_text_buffer.sv
// Character-cell text RAM fed by UART bytes: printable chars, CR, backspace and ESC
// drive a hardware cursor; a registered read port serves the pixel pipeline.
module uart_text_buffer #(
    parameter int COLS = 16,
    parameter int ROWS = 4
) (
    input  logic              CLK,
    input  logic              RST,
    uart_text_buffer_if.slave bus
);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int AW    = CW + RW;
    localparam int CELLS = COLS * ROWS;

    localparam logic [1:0] ST_CLR_ALL = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_CLR_ROW = 2'd2;

    localparam logic [7:0]    SPACE   = 8'h20;
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [1:0]    state_reg, state_next;
    logic [AW-1:0] clr_cnt_reg, clr_cnt_next;
    logic [CW-1:0] col_reg, col_next;
    logic [RW-1:0] row_reg, row_next;
    logic [7:0]    last_reg, last_next;
    logic          drop_reg, drop_next;
    logic [7:0]    rd_char_reg;

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    rx_byte;

    logic [7:0]    mem [CELLS];

    assign rx_byte = bus.i_RX_Byte;

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        col_next     = col_reg;
        row_next     = row_reg;
        last_next    = last_reg;
        drop_next    = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = {row_reg, col_reg};
        wr_data      = SPACE;

        case (state_reg)
            ST_CLR_ALL: begin
                wr_en        = 1'b1;
                wr_addr      = clr_cnt_reg;
                clr_cnt_next = clr_cnt_reg + 1'b1;
                drop_next    = bus.i_RX_DV;
                if (&clr_cnt_reg)
                    state_next = ST_IDLE;
            end
            ST_CLR_ROW: begin
                wr_en        = 1'b1;
                wr_addr      = {row_reg, clr_cnt_reg[CW-1:0]};
                clr_cnt_next = clr_cnt_reg + 1'b1;
                drop_next    = bus.i_RX_DV;
                if (clr_cnt_reg[CW-1:0] == COL_MAX)
                    state_next = ST_IDLE;
            end
            default: begin
                if (bus.i_RX_DV) begin
                    last_next = rx_byte;
                    if (rx_byte >= 8'h20 && rx_byte <= 8'h7E) begin
                        wr_en   = 1'b1;
                        wr_data = rx_byte;
                        if (col_reg != COL_MAX) begin
                            col_next = col_reg + 1'b1;
                        end else begin
                            col_next     = '0;
                            row_next     = row_reg + 1'b1;
                            clr_cnt_next = '0;
                            state_next   = ST_CLR_ROW;
                        end
                    end else if (rx_byte == 8'h0D) begin
                        col_next     = '0;
                        row_next     = row_reg + 1'b1;
                        clr_cnt_next = '0;
                        state_next   = ST_CLR_ROW;
                    end else if (rx_byte == 8'h08) begin
                        // Backspace erases the cell it lands on, crossing to the previous row end if needed
                        if (col_reg != '0) begin
                            col_next = col_reg - 1'b1;
                            wr_en    = 1'b1;
                            wr_addr  = {row_reg, col_reg - 1'b1};
                        end else if (row_reg != '0) begin
                            col_next = COL_MAX;
                            row_next = row_reg - 1'b1;
                            wr_en    = 1'b1;
                            wr_addr  = {row_reg - 1'b1, COL_MAX};
                        end
                    end else if (rx_byte == 8'h1B) begin
                        col_next     = '0;
                        row_next     = '0;
                        clr_cnt_next = '0;
                        state_next   = ST_CLR_ALL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_CLR_ALL;
            clr_cnt_reg <= '0;
            col_reg     <= '0;
            row_reg     <= '0;
            last_reg    <= 8'h00;
            drop_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            col_reg     <= col_next;
            row_reg     <= row_next;
            last_reg    <= last_next;
            drop_reg    <= drop_next;
        end
    end

    // Single write port, no reset: contents are owned by the clear sweep
    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Registered read returns pre-write data on a same-cell collision
    always_ff @(posedge CLK) begin
        if (RST)
            rd_char_reg <= SPACE;
        else
            rd_char_reg <= mem[{bus.i_Rd_Row, bus.i_Rd_Col}];
    end

    assign bus.o_Rd_Char    = rd_char_reg;
    assign bus.o_Cursor_Col = col_reg;
    assign bus.o_Cursor_Row = row_reg;
    assign bus.o_Last_Byte  = last_reg;
    assign bus.o_Busy       = (state_reg == ST_CLR_ALL) || (state_reg == ST_CLR_ROW);
    assign bus.o_Drop       = drop_reg;
endmodule

// File: tb/tb_uart_text_buffer.sv
// Self-checking bench for uart_text_buffer: vector table, directed corner sequences
// and a randomized run against a cell-array reference model.
module tb_uart_text_buffer;
    localparam int COLS  = 16;
    localparam int ROWS  = 4;
    localparam int CELLS = COLS * ROWS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_text_buffer_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    uart_text_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic [7:0] rx;
        int         exp_col;
        int         exp_row;
        logic [7:0] exp_last;
        int         rd_col;
        int         rd_row;
        logic [7:0] exp_char;
    } vec_t;

    vec_t vecs [10];

    // reference model state
    logic [7:0] m_mem [CELLS];
    int         m_col, m_row, m_busy;
    logic [7:0] m_last;

    task automatic check(input string name, input int act, input int exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_RX_DV   = 1'b1;
        bus.i_RX_Byte = b;
        tick();
        bus.i_RX_DV   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (bus.o_Busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic read_cell(input int col, input int row, output logic [7:0] ch);
        bus.i_Rd_Col = 4'(col);
        bus.i_Rd_Row = 2'(row);
        tick();
        ch = bus.o_Rd_Char;
    endtask

    task automatic count_not(input int row_lo, input int row_hi, input logic [7:0] ch, output int n);
        logic [7:0] v;
        n = 0;
        for (int r = row_lo; r <= row_hi; r++)
            for (int c = 0; c < COLS; c++) begin
                read_cell(c, r, v);
                if (v != ch) n++;
            end
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        check({name, "_col"}, int'(bus.o_Cursor_Col), col);
        check({name, "_row"}, int'(bus.o_Cursor_Row), row);
    endtask

    task automatic model_newline();
        m_row = (m_row + 1) % ROWS;
        for (int c = 0; c < COLS; c++) m_mem[m_row * COLS + c] = 8'h20;
        m_busy = COLS;
    endtask

    task automatic model_reset();
        for (int i = 0; i < CELLS; i++) m_mem[i] = 8'h20;
        m_col = 0; m_row = 0; m_last = 8'h00; m_busy = CELLS;
    endtask

    initial begin
        int         n;
        logic [7:0] v;

        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;
        bus.i_Rd_Col  = '0;
        bus.i_Rd_Row  = '0;

        vecs[0] = '{8'h48, 1, 0, 8'h48, 0, 0, 8'h48};
        vecs[1] = '{8'h69, 2, 0, 8'h69, 1, 0, 8'h69};
        vecs[2] = '{8'h0A, 2, 0, 8'h0A, 2, 0, 8'h20};
        vecs[3] = '{8'h7F, 2, 0, 8'h7F, 2, 0, 8'h20};
        vecs[4] = '{8'h80, 2, 0, 8'h80, 2, 0, 8'h20};
        vecs[5] = '{8'h08, 1, 0, 8'h08, 1, 0, 8'h20};
        vecs[6] = '{8'h7E, 2, 0, 8'h7E, 1, 0, 8'h7E};
        vecs[7] = '{8'h20, 3, 0, 8'h20, 2, 0, 8'h20};
        vecs[8] = '{8'h1F, 3, 0, 8'h1F, 0, 0, 8'h48};
        vecs[9] = '{8'hFF, 3, 0, 8'hFF, 1, 0, 8'h7E};

        // reset sweep
        do_reset();
        check("rst_busy_first", int'(bus.o_Busy), 1);
        check("rst_last", int'(bus.o_Last_Byte), 8'h00);
        check("rst_rd_char", int'(bus.o_Rd_Char), 8'h20);
        check("rst_drop", int'(bus.o_Drop), 0);
        check_cursor("rst", 0, 0);
        busy_len(n);
        check("rst_busy_len", n, CELLS);
        count_not(0, ROWS - 1, 8'h20, n);
        check("rst_cells_space", n, 0);

        // vector table
        for (int i = 0; i < 10; i++) begin
            bus.i_Rd_Col = 4'(vecs[i].rd_col);
            bus.i_Rd_Row = 2'(vecs[i].rd_row);
            send(vecs[i].rx);
            tick();
            check($sformatf("vec%0d_col", i), int'(bus.o_Cursor_Col), vecs[i].exp_col);
            check($sformatf("vec%0d_row", i), int'(bus.o_Cursor_Row), vecs[i].exp_row);
            check($sformatf("vec%0d_last", i), int'(bus.o_Last_Byte), vecs[i].exp_last);
            check($sformatf("vec%0d_busy", i), int'(bus.o_Busy), 0);
            check($sformatf("vec%0d_char", i), int'(bus.o_Rd_Char), vecs[i].exp_char);
        end

        // ESC clear
        send(8'h1B);
        check("esc_last", int'(bus.o_Last_Byte), 8'h1B);
        check_cursor("esc", 0, 0);
        busy_len(n);
        check("esc_busy_len", n, CELLS);
        count_not(0, ROWS - 1, 8'h20, n);
        check("esc_cells_space", n, 0);

        // printable run with wrap into row 1
        for (int i = 0; i < COLS; i++) send(8'h41);
        check_cursor("wrap", 0, 1);
        busy_len(n);
        check("wrap_busy_len", n, COLS);
        count_not(0, 0, 8'h41, n);
        check("wrap_row0_A", n, 0);
        count_not(1, 1, 8'h20, n);
        check("wrap_row1_space", n, 0);

        // backspace across the row boundary and at the origin
        send(8'h08);
        check_cursor("bs_cross", COLS - 1, 0);
        read_cell(COLS - 1, 0, v);
        check("bs_cross_cell", int'(v), 8'h20);
        for (int i = 0; i < COLS - 1; i++) send(8'h08);
        check_cursor("bs_home", 0, 0);
        count_not(0, 0, 8'h20, n);
        check("bs_row0_space", n, 0);
        send(8'h08);
        check_cursor("bs_origin", 0, 0);
        check("bs_origin_busy", int'(bus.o_Busy), 0);

        // strobe dropped during a row clear
        send(8'h0D);
        tick();
        send(8'h42);
        check("drop_pulse", int'(bus.o_Drop), 1);
        tick();
        check("drop_one_cycle", int'(bus.o_Drop), 0);
        busy_len(n);
        check("drop_last", int'(bus.o_Last_Byte), 8'h0D);
        check_cursor("drop", 0, 1);
        read_cell(0, 1, v);
        check("drop_not_written", int'(v), 8'h20);

        // reset in the middle of a sweep restarts it
        do_reset();
        repeat (30) tick();
        do_reset();
        busy_len(n);
        check("midrst_busy_len", n, CELLS);
        check_cursor("midrst", 0, 0);

        // same-cell read/write collision
        send(8'h61);
        send(8'h62);
        bus.i_Rd_Col = 4'd2;
        bus.i_Rd_Row = 2'd0;
        send(8'h43);
        check("collide_old", int'(bus.o_Rd_Char), 8'h20);
        tick();
        check("collide_new", int'(bus.o_Rd_Char), 8'h43);

        // randomized run against the reference model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic       dv;
            logic [7:0] b;
            int         r, rc, rr, exp_drop, rd_valid;
            logic [7:0] exp_rd;

            r  = int'($urandom_range(0, 99));
            if (r < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 80) b = 8'h08;
            else if (r < 86) b = 8'h0D;
            else if (r < 88) b = 8'h1B;
            else             b = 8'($urandom_range(0, 255));
            dv = ($urandom_range(0, 3) != 0);
            rc = int'($urandom_range(0, COLS - 1));
            rr = int'($urandom_range(0, ROWS - 1));

            rd_valid = (m_busy == 0);
            exp_rd   = m_mem[rr * COLS + rc];
            exp_drop = 0;
            if (m_busy > 0) begin
                m_busy--;
                if (dv) exp_drop = 1;
            end else if (dv) begin
                m_last = b;
                if (b >= 8'h20 && b <= 8'h7E) begin
                    m_mem[m_row * COLS + m_col] = b;
                    if (m_col < COLS - 1) m_col++;
                    else begin
                        m_col = 0;
                        model_newline();
                    end
                end else if (b == 8'h0D) begin
                    m_col = 0;
                    model_newline();
                end else if (b == 8'h08) begin
                    if (m_col > 0) begin
                        m_col--;
                        m_mem[m_row * COLS + m_col] = 8'h20;
                    end else if (m_row > 0) begin
                        m_row--;
                        m_col = COLS - 1;
                        m_mem[m_row * COLS + m_col] = 8'h20;
                    end
                end else if (b == 8'h1B) begin
                    m_col = 0;
                    m_row = 0;
                    for (int i = 0; i < CELLS; i++) m_mem[i] = 8'h20;
                    m_busy = CELLS;
                end
            end

            bus.i_Rd_Col  = 4'(rc);
            bus.i_Rd_Row  = 2'(rr);
            bus.i_RX_DV   = dv;
            bus.i_RX_Byte = b;
            tick();
            bus.i_RX_DV   = 1'b0;

            check($sformatf("rnd%0d_col", cyc), int'(bus.o_Cursor_Col), m_col);
            check($sformatf("rnd%0d_row", cyc), int'(bus.o_Cursor_Row), m_row);
            check($sformatf("rnd%0d_last", cyc), int'(bus.o_Last_Byte), int'(m_last));
            check($sformatf("rnd%0d_busy", cyc), int'(bus.o_Busy), int'(m_busy > 0));
            check($sformatf("rnd%0d_drop", cyc), int'(bus.o_Drop), exp_drop);
            if (rd_valid != 0)
                check($sformatf("rnd%0d_rd", cyc), int'(bus.o_Rd_Char), int'(exp_rd));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/uart_text_buffer.md
# uart_text_buffer

Character-cell text store between the UART receiver and the VGA pattern generator. It takes each received byte (data-valid strobe plus byte), interprets printable ASCII and a small set of control codes, and writes characters into a COLS×ROWS text RAM at a hardware cursor. A registered read port lets the pixel pipeline fetch the character for any cell, so typed keyboard text can be drawn on screen.

## Interface
Parameters:
- COLS, 16: text columns. Power of two, at least 2.
- ROWS, 4: text rows. Power of two, at least 2.
- CW = clog2(COLS), RW = clog2(ROWS): derived widths. Not overridable.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset, synchronous, active-high.
- i_RX_DV  in  1  one-cycle strobe: i_RX_Byte is valid.
- i_RX_Byte  in  8  received byte.
- i_Rd_Col  in  CW  read column address.
- i_Rd_Row  in  RW  read row address.
- o_Rd_Char  out  8  character at the read address, registered.
- o_Cursor_Col  out  CW  current cursor column.
- o_Cursor_Row  out  RW  current cursor row.
- o_Last_Byte  out  8  last accepted byte, including control codes.
- o_Busy  out  1  high while a clear sweep runs.
- o_Drop  out  1  one-cycle pulse: a strobed byte was discarded.

## Operation
- Storage: COLS×ROWS bytes, addressed as {row, col}.
- State machine has three states: CLR_ALL, IDLE, CLR_ROW.
- CLR_ALL:
  - A clear counter walks all COLS×ROWS cells in order, one per cycle, writing 0x20.
  - Returns to IDLE after the last cell.
- CLR_ROW:
  - Writes 0x20 to the COLS cells of the cursor row, one per cycle, starting at col 0.
  - Returns to IDLE after the last cell.
- o_Busy = 1 in both clear states.
- A strobe received while o_Busy = 1 is discarded: no write, no cursor change, o_Last_Byte unchanged, o_Drop pulses.
- In IDLE, a strobe is accepted. o_Last_Byte ← byte. The byte is decoded as follows:
  - **0x20–0x7E (printable):**
    - Write the byte at the cursor.
    - If col < COLS-1: col ← col+1.
    - Otherwise: col ← 0, row ← (row+1) mod ROWS, enter CLR_ROW.
  - **0x0D (CR):** col ← 0, row ← (row+1) mod ROWS, enter CLR_ROW.
  - **0x08 (backspace):**
    - If col > 0: col ← col-1, then write 0x20 at the new position.
    - If col = 0 and row > 0: move to (COLS-1, row-1) and write 0x20 there.
    - At (0,0): no write, no move.
  - **0x1B (ESC):** cursor ← (0,0), enter CLR_ALL.
  - **Any other byte (including 0x0A, 0x7F, ≥0x80):** accepted but ignored. No write, no cursor change.
- Row wrap: wrapping from row ROWS-1 goes to row 0 and clears it. There is no scrolling.
- Reset:
  - Cursor ← (0,0), o_Last_Byte ← 0x00, o_Rd_Char ← 0x20, o_Drop ← 0.
  - State ← CLR_ALL, so o_Busy = 1 in the first cycle after reset.
  - RAM contents are not reset directly; the CLR_ALL sweep clears them.
- Reset asserted mid-clear or mid-operation: the sweep restarts from cell 0.

## Timing
- All state updates happen on the rising CLK edge.
- Accepted byte:
  - RAM write, cursor update and o_Last_Byte update all take effect at the edge that samples i_RX_DV = 1.
  - Updated cursor and o_Last_Byte are visible the following cycle.
- Read port:
  - Latency is 1 cycle: address sampled at edge N, o_Rd_Char valid after edge N.
  - A read and write to the same cell at the same edge return the old data. The new data appears one cycle later.
- Clear sweeps:
  - CLR_ALL lasts exactly COLS×ROWS cycles; CLR_ROW lasts exactly COLS cycles.
  - o_Busy drops in the cycle after the last clear write.
  - A strobe in that first cycle with o_Busy = 0 is accepted.
- Reset to IDLE: 64 cycles with default parameters.
- Strobe on the same edge the state machine leaves IDLE: the leaving byte (CR, wrap or ESC) is itself accepted. Strobes from the next cycle onward are dropped until o_Busy falls.
- o_Drop is high for exactly one cycle per discarded strobe.
- Back-to-back strobes on consecutive cycles in IDLE are each accepted, provided no clear is triggered.

## Test plan
- **Reset sweep:** assert RST for 1 cycle, release.
  - o_Busy is high for 64 cycles, then low.
  - Reading every cell returns 0x20; cursor is (0,0); o_Last_Byte = 0x00.
- **Printable and wrap:** send 0x41 ('A') 16 times.
  - Cells (0..15, 0) = 0x41.
  - Cursor becomes (0,1); o_Busy is high for 16 cycles; row 1 reads all 0x20.
- **Backspace:** from (0,1) send 0x08.
  - Cursor becomes (15,0); cell (15,0) = 0x20.
  - Send 0x08 fifteen more times, then once more at (0,0): cursor stays (0,0), no write.
- **Drop during clear:** send 0x0D, then 0x42 two cycles later.
  - o_Drop pulses once; 0x42 is not written; o_Last_Byte = 0x0D.
- **ESC clear:** fill cells, send 0x1B.
  - o_Busy is high for 64 cycles; all cells read 0x20; cursor is (0,0).
- **Reset mid-sweep and read collision:**
  - Assert RST at sweep cycle 30: sweep restarts and lasts 64 cycles.
  - Write 0x43 to (2,0) while reading (2,0) at the same edge: first o_Rd_Char = 0x20, next cycle 0x43.
